// File: rtl/red_pitaya_dacbuf_pkg.sv
// Shared constants and state encoding for the ASG channel DAC ping-pong buffer
// (used by the fill writer and the channel model).
package red_pitaya_dacbuf_pkg;

  localparam int AW         = 12;
  localparam int HALF_WORDS = 2 ** (AW - 1);
  localparam int WORD_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_WAIT    = 2'd2,
    ST_FILL    = 2'd3
  } fill_state_e;

endpackage

// File: rtl/red_pitaya_dacbuf_stats.sv
// Fill statistics: saturating abort counter and wrapping written-word counter.
// Both clear only on reset.
module red_pitaya_dacbuf_stats (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        abort_i,
  input  logic        wr_i,
  output logic [15:0] underrun_cnt_o,
  output logic [31:0] word_cnt_o
);

  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    word_cnt_d     = word_cnt_q;
    if (abort_i && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
    if (wr_i) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      underrun_cnt_q <= '0;
      word_cnt_q     <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      word_cnt_q     <= word_cnt_d;
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
  assign word_cnt_o     = word_cnt_q;

endmodule

// File: rtl/red_pitaya_dacbuf_fill.sv
// DAC buffer writer: prefills the whole ping-pong buffer, then refills each half as the reader vacates it.
// Optional counters on underrun_cnt_o/word_cnt_o are built only with DACBUF_FILL_STATS_EN defined.
module red_pitaya_dacbuf_fill
  import red_pitaya_dacbuf_pkg::*;
(
  input  logic              dacbuf_clk_i,
  input  logic              dacbuf_rstn_i,
  input  logic              en_i,
  input  logic [WORD_W-1:0] src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  input  logic [1:0]        dacbuf_ready_i,
  input  logic [1:0]        dacbuf_close_i,
  output logic              dacbuf_select_o,
  output logic [AW-1:0]     dacbuf_waddr_o,
  output logic [WORD_W-1:0] dacbuf_wdata_o,
  output logic              dacbuf_valid_o,
  output logic              fill_busy_o,
  output logic              fill_half_o,
  output logic              underrun_o,
  output logic [15:0]       underrun_cnt_o,
  output logic [31:0]       word_cnt_o
);

  localparam logic [AW-2:0] HALF_LAST = '1;

  fill_state_e       state_q, state_d;
  logic [1:0]        pending_q, pending_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              half_q, half_d;
  logic              underrun_q, underrun_d;
  logic              select_q, select_d;
  logic              busy_q, busy_d;
  logic              wr_vld_q, wr_vld_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic [1:0]    pend_eff;
  logic [1:0]    qualify;
  logic [1:0]    pend_clr;
  logic          prefill_done;
  logic          src_rdy;
  logic          accept;
  logic          abort;
  logic [AW-1:0] wr_addr;

  // A ready pulse in the decision cycle counts immediately, so refill starts one cycle after it.
  assign pend_eff = pending_q | dacbuf_ready_i;
  assign qualify  = pend_eff & ~dacbuf_close_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    underrun_d   = underrun_q;
    pend_clr     = 2'b00;
    prefill_done = 1'b0;
    src_rdy      = 1'b0;
    abort        = 1'b0;
    wr_addr      = waddr_q;

    if (!en_i) begin
      state_d    = ST_IDLE;
      underrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PREFILL;
          cnt_d   = '0;
        end
        ST_PREFILL: begin
          src_rdy = 1'b1;
          if (src_valid_i) begin
            wr_addr = cnt_q;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == '1) begin
              state_d      = ST_WAIT;
              prefill_done = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (qualify != 2'b00) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            half_d  = (qualify == 2'b11) ? ~half_q : qualify[1];
          end
        end
        ST_FILL: begin
          src_rdy = ~dacbuf_close_i[half_q];
          if (dacbuf_close_i[half_q]) begin
            // Close at count 0 just stalls; only a partly written half is an underrun.
            if (cnt_q[AW-2:0] != '0) begin
              abort            = 1'b1;
              underrun_d       = 1'b1;
              pend_clr[half_q] = 1'b1;
              state_d          = ST_WAIT;
            end
          end else if (src_valid_i) begin
            wr_addr = {half_q, cnt_q[AW-2:0]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q[AW-2:0] == HALF_LAST) begin
              pend_clr[half_q] = 1'b1;
              state_d          = ST_WAIT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign accept = src_rdy & src_valid_i;

  always_comb begin
    if (!en_i || prefill_done) begin
      pending_d = 2'b00;
    end else begin
      pending_d = (pending_q & ~pend_clr) | dacbuf_ready_i;
    end
  end

  always_comb begin
    wr_vld_d = accept;
    waddr_d  = accept ? wr_addr : waddr_q;
    wdata_d  = accept ? src_data_i : wdata_q;
    select_d = (state_d != ST_IDLE);
    busy_d   = (state_d == ST_PREFILL) || (state_d == ST_FILL);
  end

  always_ff @(posedge dacbuf_clk_i or negedge dacbuf_rstn_i) begin
    if (!dacbuf_rstn_i) begin
      state_q    <= ST_IDLE;
      pending_q  <= 2'b00;
      cnt_q      <= '0;
      half_q     <= 1'b0;
      underrun_q <= 1'b0;
      select_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_vld_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      underrun_q <= underrun_d;
      select_q   <= select_d;
      busy_q     <= busy_d;
      wr_vld_q   <= wr_vld_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign src_ready_o     = src_rdy;
  assign dacbuf_select_o = select_q;
  assign dacbuf_waddr_o  = waddr_q;
  assign dacbuf_wdata_o  = wdata_q;
  assign dacbuf_valid_o  = wr_vld_q;
  assign fill_busy_o     = busy_q;
  assign fill_half_o     = half_q;
  assign underrun_o      = underrun_q;

`ifdef DACBUF_FILL_STATS_EN
  red_pitaya_dacbuf_stats u_stats (
    .clk_i          (dacbuf_clk_i),
    .rstn_i         (dacbuf_rstn_i),
    .abort_i        (abort),
    .wr_i           (wr_vld_q),
    .underrun_cnt_o (underrun_cnt_o),
    .word_cnt_o     (word_cnt_o)
  );
`else
  assign underrun_cnt_o = 16'd0;
  assign word_cnt_o     = 32'd0;
`endif

endmodule

// File: tb/tb_red_pitaya_dacbuf_fill.sv
// Directed bench for the DAC buffer writer: prefill, table of refill scenarios, abort and disable.
module tb_red_pitaya_dacbuf_fill;
  import red_pitaya_dacbuf_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic              en;
  logic [WORD_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic [1:0]        rdy_in;
  logic [1:0]        cls_in;
  logic              sel;
  logic [AW-1:0]     waddr;
  logic [WORD_W-1:0] wdata;
  logic              wvld;
  logic              busy;
  logic              half;
  logic              unr;
  logic [15:0]       unr_cnt;
  logic [31:0]       wcnt;

  red_pitaya_dacbuf_fill dut (
    .dacbuf_clk_i    (clk),
    .dacbuf_rstn_i   (rstn),
    .en_i            (en),
    .src_data_i      (src_data),
    .src_valid_i     (src_valid),
    .src_ready_o     (src_ready),
    .dacbuf_ready_i  (rdy_in),
    .dacbuf_close_i  (cls_in),
    .dacbuf_select_o (sel),
    .dacbuf_waddr_o  (waddr),
    .dacbuf_wdata_o  (wdata),
    .dacbuf_valid_o  (wvld),
    .fill_busy_o     (busy),
    .fill_half_o     (half),
    .underrun_o      (unr),
    .underrun_cnt_o  (unr_cnt),
    .word_cnt_o      (wcnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  int n_writes = 0;
  int seg_acc  = 0;
  longint unsigned beat_idx = 0;

  logic [AW-1:0]     wq_addr[$];
  logic [WORD_W-1:0] wq_dat[$];
  int                wq_cyc[$];
  logic [WORD_W-1:0] aq_dat[$];
  int                aq_cyc[$];

  typedef struct {
    logic [1:0] rdy;
    logic [1:0] cls;
    logic [1:0] rdy_last;
    int         abort_at;
    bit         bp;
    logic       exp_half;
    logic       exp_unr;
  } vec_t;

  vec_t vecs[5];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (wvld === 1'b1) begin
      wq_addr.push_back(waddr);
      wq_dat.push_back(wdata);
      wq_cyc.push_back(cyc_cnt);
      n_writes++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: present a beat, record it if accepted, end at next posedge+1.
  task automatic cyc(input logic vld, output logic rdy_seen);
    src_valid = vld;
    src_data  = beat_idx;
    #1;
    rdy_seen = src_ready;
    if (vld && src_ready) begin
      aq_dat.push_back(beat_idx);
      aq_cyc.push_back(cyc_cnt);
      beat_idx++;
      seg_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq_addr.delete(); wq_dat.delete(); wq_cyc.delete();
    aq_dat.delete(); aq_cyc.delete();
    seg_acc = 0;
  endtask

  // Each write must land at base+i, carry the i-th accepted word, one cycle after its accept.
  function automatic int run_errs(input int base);
    int e = 0;
    for (int i = 0; i < wq_addr.size(); i++) begin
      if (i >= aq_dat.size()) e++;
      else if (int'(wq_addr[i]) != base + i || wq_dat[i] != aq_dat[i] || wq_cyc[i] != aq_cyc[i] + 1) e++;
    end
    return e;
  endfunction

  initial begin
    logic r;
    int   guard;
    int   n;

    vecs[0] = '{rdy:2'b10, cls:2'b01, rdy_last:2'b00, abort_at:0,   bp:1'b0, exp_half:1'b1, exp_unr:1'b0};
    vecs[1] = '{rdy:2'b01, cls:2'b00, rdy_last:2'b00, abort_at:0,   bp:1'b1, exp_half:1'b0, exp_unr:1'b0};
    vecs[2] = '{rdy:2'b11, cls:2'b00, rdy_last:2'b00, abort_at:0,   bp:1'b0, exp_half:1'b1, exp_unr:1'b0};
    vecs[3] = '{rdy:2'b00, cls:2'b00, rdy_last:2'b01, abort_at:0,   bp:1'b0, exp_half:1'b0, exp_unr:1'b0};
    vecs[4] = '{rdy:2'b00, cls:2'b00, rdy_last:2'b00, abort_at:100, bp:1'b0, exp_half:1'b0, exp_unr:1'b1};

    rstn = 1'b0; en = 1'b0; src_valid = 1'b0; src_data = '0; rdy_in = 2'b00; cls_in = 2'b00;
    #20;
    chk("rst_select", sel, 1'b0);
    chk("rst_valid", wvld, 1'b0);
    chk("rst_waddr", waddr, '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_half", half, 1'b0);
    chk("rst_underrun", unr, 1'b0);
    chk("rst_src_ready", src_ready, 1'b0);
    chk("rst_unr_cnt", unr_cnt, 16'd0);
    chk("rst_word_cnt", wcnt, 32'd0);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Prefill of the whole buffer
    clear_q();
    en = 1'b1;
    cyc(1'b1, r);
    chk("idle_no_accept", r, 1'b0);
    chk("prefill_busy", busy, 1'b1);
    chk("prefill_select", sel, 1'b1);
    seg_acc = 0;
    guard = 0;
    while (seg_acc < 4096 && guard < 5000) begin
      cyc(1'b1, r);
      guard++;
    end
    chk("prefill_timeout", seg_acc, 4096);
    chk("prefill_rdy_after", src_ready, 1'b0);
    chk("prefill_wait_busy", busy, 1'b0);
    chk("prefill_wait_select", sel, 1'b1);
    cyc(1'b0, r);
    chk("prefill_nwrites", wq_addr.size(), 4096);
    chk("prefill_run", run_errs(0), 0);

    // Refill scenarios
    foreach (vecs[k]) begin
      clear_q();
      cls_in = vecs[k].cls;
      rdy_in = vecs[k].rdy;
      cyc(1'b0, r);
      rdy_in = 2'b00;
      chk($sformatf("v%0d_enter_busy", k), busy, 1'b1);
      chk($sformatf("v%0d_half", k), half, vecs[k].exp_half);
      n = (vecs[k].abort_at != 0) ? vecs[k].abort_at : HALF_WORDS;
      guard = 0;
      while (seg_acc < n && guard < 20000) begin
        logic v;
        v = vecs[k].bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (seg_acc == n - 1 && v) rdy_in = vecs[k].rdy_last;
        cyc(v, r);
        rdy_in = 2'b00;
        guard++;
      end
      chk($sformatf("v%0d_accepts", k), seg_acc, n);
      if (vecs[k].abort_at != 0) begin
        cls_in = vecs[k].cls | (2'b01 << vecs[k].exp_half);
        cyc(1'b1, r);
        chk($sformatf("v%0d_abort_rdy", k), r, 1'b0);
      end
      chk($sformatf("v%0d_done_busy", k), busy, 1'b0);
      chk($sformatf("v%0d_underrun", k), unr, vecs[k].exp_unr);
      cyc(1'b0, r);
      cls_in = 2'b00;
      chk($sformatf("v%0d_nwrites", k), wq_addr.size(), n);
      chk($sformatf("v%0d_run", k), run_errs(vecs[k].exp_half ? HALF_WORDS : 0), 0);
      if (wq_addr.size() > 0)
        chk($sformatf("v%0d_last_addr", k), wq_addr[wq_addr.size()-1],
            (vecs[k].exp_half ? HALF_WORDS : 0) + n - 1);
    end

    // No pending half left after the abort: nothing starts
    cyc(1'b0, r);
    cyc(1'b0, r);
    chk("idle_wait_busy", busy, 1'b0);

    // Disable in the middle of a fill
    clear_q();
    rdy_in = 2'b10;
    cyc(1'b0, r);
    rdy_in = 2'b00;
    chk("dis_enter_busy", busy, 1'b1);
    chk("dis_enter_half", half, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, r);
    chk("dis_unr_sticky", unr, 1'b1);
    en = 1'b0;
    cyc(1'b1, r);
    chk("dis_rdy", r, 1'b0);
    chk("dis_busy", busy, 1'b0);
    chk("dis_select", sel, 1'b0);
    chk("dis_underrun", unr, 1'b0);
    cyc(1'b0, r);
    chk("dis_nwrites", wq_addr.size(), 10);
    chk("dis_run", run_errs(HALF_WORDS), 0);
    chk("dis_no_valid", wvld, 1'b0);

`ifdef DACBUF_FILL_STATS_EN
    chk("stat_word_cnt", wcnt, n_writes);
    chk("stat_unr_cnt", unr_cnt, 16'd1);
`else
    chk("stat_word_cnt", wcnt, 32'd0);
    chk("stat_unr_cnt", unr_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/red_pitaya_dacbuf_fill.md
# red_pitaya_dacbuf_fill

Writer side of the ASG channel DAC data buffer. Takes a 64-bit sample stream (four 16-bit samples per word) from the host/DMA path and writes it into the channel's 16k-sample ping-pong buffer, one 8k half at a time. It uses the channel's per-half ready pulses and close levels to decide when each half may be refilled. It sits in the dacbuf clock domain between the stream source and the channel's `dacbuf_*` write port.

## Interface
- `AW`, 12, word address width; the buffer is 2^AW words and each half is `HALF_WORDS` = 2^(AW-1) = 2048 words.
- `dacbuf_clk_i` in 1: buffer clock; the only clock.
- `dacbuf_rstn_i` in 1: reset, asynchronous, active-low.
- `en_i` in 1: fill enable, level.
- `src_data_i` in 64: stream data.
- `src_valid_i` in 1: stream valid.
- `src_ready_o` out 1: stream ready; a beat transfers when valid and ready are both high.
- `dacbuf_ready_i` in 2: one-cycle pulse meaning half h (bit 0 = 0k-8k, bit 1 = 8k-16k) has been vacated by the reader.
- `dacbuf_close_i` in 2: level meaning half h must not be written; already synchronized.
- `dacbuf_select_o` out 1: channel buffer select.
- `dacbuf_waddr_o` out AW: write word address.
- `dacbuf_wdata_o` out 64: write data.
- `dacbuf_valid_o` out 1: write strobe.
- `fill_busy_o` out 1: high in PREFILL or FILL.
- `fill_half_o` out 1: half currently being filled.
- `underrun_o` out 1: sticky; set on abort.
- `underrun_cnt_o` out 16: abort count (only with stats; see Configuration).
- `word_cnt_o` out 32: words written (only with stats; see Configuration).

## Operation
- Reset: every output is 0, the state is IDLE, `pending` = 2'b00, and the word counter is 0.
- States: IDLE, PREFILL, WAIT, FILL.
- IDLE -> PREFILL on the cycle `en_i` is first sampled high.
  - In PREFILL, `src_ready_o` = 1.
  - Words are written to addresses 0..2^AW-1 in order. `dacbuf_close_i` is ignored because the reader is assumed stopped.
  - After the last word: -> WAIT with `pending` = 2'b00.
- Pending flags:
  - `dacbuf_ready_i[h]` sets `pending[h]`.
  - Completion or abort of half h clears it.
  - A set and a clear in the same cycle resolve as set.
- WAIT -> FILL(h) when `pending[h]` = 1 and `dacbuf_close_i[h]` = 0.
  - If both halves qualify, pick the half opposite to the last one filled.
  - The word counter is cleared on entry.
- In FILL(h), `src_ready_o` = !`dacbuf_close_i[h]` (combinational).
  - Each accepted beat writes address {h, cnt}, then `cnt` increments.
  - Accepting the beat with `cnt` = `HALF_WORDS`-1 completes the half: clear `pending[h]`, go to WAIT.
- Abort: `dacbuf_close_i[h]` = 1 while in FILL(h) with `cnt` ≠ 0.
  - Set `underrun_o`, clear `pending[h]`, go to WAIT.
  - Unconsumed source words remain in the source.
  - `close` already high when FILL is entered cannot happen, because WAIT checks it.
- `en_i` low in any state:
  - Next state is IDLE and `pending` is cleared.
  - `underrun_o` is cleared.
  - No beat is accepted that cycle.
  - A write already registered still issues.
- `dacbuf_select_o` = (state ≠ IDLE), registered.
- The address counter is AW-1 bits in FILL and AW bits in PREFILL. It never wraps past the end of a half; completion triggers first.

## Timing
- Beat accepted at cycle N -> `dacbuf_valid_o` = 1 at N+1, with `dacbuf_waddr_o` and `dacbuf_wdata_o` registered from cycle N.
- `dacbuf_valid_o` is 0 in all other cycles. Address and data hold their last value.
- Sustained throughput is 1 word/cycle, so a half needs a minimum of 2048 cycles.
- `dacbuf_ready_i` pulse at cycle N -> earliest FILL entry at N+1 and earliest `src_ready_o` = 1 at N+1. State change is one cycle after a registered decision.
- The close-based abort takes effect on the same cycle for `src_ready_o` (combinational gate). The state reaches WAIT at the next edge.
- `fill_busy_o`, `fill_half_o` and `underrun_o` are registered and track the state with no extra delay.

## Configuration
- `DACBUF_FILL_STATS_EN` defined:
  - `underrun_cnt_o` increments on each abort and saturates at 16'hFFFF.
  - `word_cnt_o` increments on each `dacbuf_valid_o` cycle and wraps modulo 2^32.
  - Both counters clear only on reset.
- `DACBUF_FILL_STATS_EN` not defined: both outputs are tied to 0 and no counter logic is synthesized. All other behaviour is identical.

## Structure
- Package `red_pitaya_dacbuf_pkg` holds the state enum (IDLE, PREFILL, WAIT, FILL), `AW`, `HALF_WORDS` and `WORD_W` = 64. The ASG channel model uses the same package.
- One sub-module, `red_pitaya_dacbuf_stats`: the two counters. It is instantiated only under `DACBUF_FILL_STATS_EN`.

## Test plan
- Prefill:
  - Stimulus: `en_i` rises; source supplies 4096 words with data = index, continuously valid.
  - Required: writes go to addresses 0..4095 on consecutive cycles, each one cycle after its accept; `src_ready_o` falls after word 4095; state is WAIT.
- Refill half 1:
  - Stimulus: after prefill, hold `close_i` = 2'b01 and pulse `ready_i` = 2'b10.
  - Required: FILL(1) is entered one cycle later; 2048 writes to addresses 2048..4095; `pending` returns to 0.
- Abort:
  - Stimulus: during FILL(0), after 100 accepted beats, raise `close_i[0]`.
  - Required: `src_ready_o` = 0 in the same cycle; last write goes to address 99; `underrun_o` = 1; `underrun_cnt_o` = 1 when stats are enabled.
- Both halves pending:
  - Stimulus: the last filled half is 0; pulse `ready_i` = 2'b11 with `close_i` = 0.
  - Required: half 1 is filled first, then half 0.
- Set/clear collision and disable:
  - Stimulus: a `ready_i[0]` pulse on the completion cycle of FILL(0).
  - Required: half 0 is refilled.
  - Stimulus: `en_i` dropped mid-fill.
  - Required: IDLE next cycle, `dacbuf_select_o` = 0, `underrun_o` cleared.
- Source backpressure:
  - Stimulus: `src_valid_i` toggles randomly during FILL.
  - Required: addresses stay contiguous with no gaps or duplicates; `word_cnt_o` equals the number of writes.
